// File: rtl/timer_multimode.sv
// rtl/timer_multimode.sv - multimode prescaled timer with snapshot output
module timer_multimode #(
   parameter int WIDTH = 16,
   parameter int PRESC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             t_start,
   input  logic             t_clr,
   input  logic [1:0]       t_mode,
   input  logic [WIDTH-1:0] t_limit,
   input  logic             t_en,
   output logic             t_valid,
   output logic [WIDTH-1:0] t_out,
   output logic             t_wrap
);

   localparam int            PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESC - 1);

   localparam logic [1:0] M_FREE     = 2'b00;
   localparam logic [1:0] M_RELOAD   = 2'b01;
   localparam logic [1:0] M_ONESHOT  = 2'b10;
   localparam logic [1:0] M_PERIODIC = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    psc_q, psc_d;
   logic [1:0]       mode_q, mode_d;
   logic             wrap_d;
   logic [WIDTH-1:0] cnt_inc;

   assign cnt_inc = cnt_q + WIDTH'(1);

   // State register: the only place the FSM state changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and counter update; clear wins over start, start only counts outside RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      psc_d   = psc_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;
      if (t_clr) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         psc_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (t_start) begin
                  state_d = S_RUN;
                  mode_d  = t_mode;
                  cnt_d   = (t_mode == M_RELOAD) ? t_limit : '0;
                  psc_d   = '0;
               end
            end
            S_RUN: begin
               if (psc_q == PSC_LAST) begin
                  psc_d = '0;
                  case (mode_q)
                     M_FREE: begin
                        cnt_d  = cnt_inc;
                        wrap_d = (cnt_q == {WIDTH{1'b1}});
                     end
                     M_RELOAD: begin
                        if (cnt_q == '0) begin
                           cnt_d  = t_limit;
                           wrap_d = 1'b1;
                        end else begin
                           cnt_d = cnt_q - WIDTH'(1);
                        end
                     end
                     M_ONESHOT: begin
                        // A limit already passed (e.g. lowered live) terminates at once.
                        if ((cnt_q >= t_limit) || (cnt_inc == t_limit)) begin
                           cnt_d   = t_limit;
                           state_d = S_DONE;
                           wrap_d  = 1'b1;
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                     M_PERIODIC: begin
                        if (cnt_q >= t_limit) begin
                           cnt_d  = '0;
                           wrap_d = 1'b1;
                        end else begin
                           cnt_d = cnt_inc;
                        end
                     end
                     default: cnt_d = cnt_q;
                  endcase
               end else begin
                  psc_d = psc_q + PW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath registers plus snapshot and wrap strobes; snapshot takes the pre-update count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         psc_q   <= '0;
         mode_q  <= M_FREE;
         t_out   <= '0;
         t_valid <= 1'b0;
         t_wrap  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         psc_q   <= psc_d;
         mode_q  <= mode_d;
         t_wrap  <= wrap_d;
         t_valid <= t_en;
         if (t_en) begin
            t_out <= cnt_q;
         end
      end
   end

endmodule
